// File: rtl/perceptron_driver_if.sv
// Link between perceptron_driver (master) and the perceptron top (slave):
// vector val/rdy handshake, serial weight programming and decision handshake.
interface perceptron_driver_if #(
  parameter int WIDTH = 8
) ();
  logic             val_o;
  logic             rdy_i;
  logic [WIDTH-1:0] X0_o;
  logic [WIDTH-1:0] X1_o;
  logic [1:0]       W1W0b_en_o;
  logic             b_o;
  logic             W0_o;
  logic             W1_o;
  logic             val_i;
  logic             rdy_o;
  logic             Y_i;

  modport master (
    output val_o, X0_o, X1_o, W1W0b_en_o, b_o, W0_o, W1_o, rdy_o,
    input  rdy_i, val_i, Y_i
  );

  modport slave (
    input  val_o, X0_o, X1_o, W1W0b_en_o, b_o, W0_o, W1_o, rdy_o,
    output rdy_i, val_i, Y_i
  );
endinterface

// File: rtl/perceptron_driver.sv
// Stimulus source / result sink for the perceptron: input FIFO, weight programming
// sequencer and decision counters. Define PERCEPTRON_DRV_HIST_EN to build the decision history.
module perceptron_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  perceptron_driver_if.master pif,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_x0_i,
  input  logic [WIDTH-1:0] push_x1_i,
  output logic             full_o,
  input  logic             wt_load_i,
  input  logic             wt_b_i,
  input  logic             wt_w0_i,
  input  logic             wt_w1_i,
  output logic             wt_busy_o,
  output logic [15:0]      res_cnt_o,
  output logic [15:0]      pos_cnt_o,
  output logic             err_o,
  output logic [7:0]       hist_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 2);

  typedef enum logic [2:0] {
    HOLD, PROG_B, PROG_W0, PROG_W1, STREAM, DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] x0_mem_q [DEPTH];
  logic [WIDTH-1:0] x1_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   out_q, out_d;
  logic            pending_q, pending_d;
  logic            b_q, b_d, w0_q, w0_d, w1_q, w1_d;
  logic [15:0]     res_q, res_d, pos_q, pos_d;
  logic            err_q, err_d;

  logic empty, full, val, rdy;
  logic push_acc, load_acc, pend_now, vec_hs, dec_hs;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign val      = (state_q == STREAM) && !empty;
  assign rdy      = !reset;
  assign push_acc = push_i && !full;
  assign load_acc = wt_load_i && !pending_q;
  assign pend_now = pending_q || load_acc;
  assign vec_hs   = val && pif.rdy_i;
  assign dec_hs   = pif.val_i && rdy;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    pending_d = pending_q;
    b_d       = b_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    res_d     = res_q;
    pos_d     = pos_q;
    err_d     = err_q;

    // full is judged before the pop, so a push into a full FIFO is lost even when a pop happens
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (vec_hs)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_acc, vec_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({vec_hs, dec_hs})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = (out_q == '0) ? out_q : out_q - OW'(1);
      default: out_d = out_q;
    endcase
    if (dec_hs && (out_q == '0)) err_d = 1'b1;
    if (dec_hs) begin
      res_d = res_q + 16'd1;
      if (pif.Y_i) pos_d = pos_q + 16'd1;
    end

    if (load_acc) begin
      pending_d = 1'b1;
      b_d       = wt_b_i;
      w0_d      = wt_w0_i;
      w1_d      = wt_w1_i;
    end else if (state_q == PROG_W1) begin
      pending_d = 1'b0;
    end

    case (state_q)
      HOLD:    if (pend_now) state_d = PROG_B;
      PROG_B:  state_d = PROG_W0;
      PROG_W0: state_d = PROG_W1;
      PROG_W1: state_d = STREAM;
      // a presented vector must complete its handshake before programming may start
      STREAM:  if (pend_now && (!val || pif.rdy_i)) state_d = DRAIN;
      DRAIN:   if (out_q == '0) state_d = PROG_B;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HOLD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      pending_q <= 1'b0;
      b_q       <= 1'b0;
      w0_q      <= 1'b0;
      w1_q      <= 1'b0;
      res_q     <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      b_q       <= b_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      res_q     <= res_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is tracked by cnt_q, and the outputs mask stale data.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      x0_mem_q[wr_ptr_q] <= push_x0_i;
      x1_mem_q[wr_ptr_q] <= push_x1_i;
    end
  end

`ifdef PERCEPTRON_DRV_HIST_EN
  logic [7:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (dec_hs) hist_d = {hist_q[6:0], pif.Y_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign hist_o = hist_q;
`else
  assign hist_o = '0;
`endif

  always_comb begin
    pif.W1W0b_en_o = 2'b00;
    case (state_q)
      PROG_B:  pif.W1W0b_en_o = 2'b01;
      PROG_W0: pif.W1W0b_en_o = 2'b10;
      PROG_W1: pif.W1W0b_en_o = 2'b11;
      default: pif.W1W0b_en_o = 2'b00;
    endcase
  end

  assign pif.val_o  = val;
  assign pif.X0_o   = val ? x0_mem_q[rd_ptr_q] : '0;
  assign pif.X1_o   = val ? x1_mem_q[rd_ptr_q] : '0;
  assign pif.b_o    = b_q;
  assign pif.W0_o   = w0_q;
  assign pif.W1_o   = w1_q;
  assign pif.rdy_o  = rdy;
  assign full_o     = full;
  assign wt_busy_o  = pending_q;
  assign res_cnt_o  = res_q;
  assign pos_cnt_o  = pos_q;
  assign err_o      = err_q;

endmodule
